// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/response port: one outstanding request, variable latency.
// The fetch stage drives through the master modport; the memory answers through slave.
interface instr_fetch_stage_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// IF stage: owns PC_F, one-outstanding imem port and the IF/ID register (FETCH_PERF_CNT_EN adds counters).
// Latency: request in ISSUE, IF/ID loads on the edge imem_valid is seen; at best one instr per 2 cycles.
// Backpressure: StallD parks an arriving response in a one-entry skid buffer until decode accepts it.
module instr_fetch_stage #(
    parameter int                     ADDR_WIDTH  = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = 32'h0000_0000,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   StallD,
    input  logic                   FlushD,
    input  logic                   PCSrc_E,
    input  logic [ADDR_WIDTH-1:0]  PCTarget_E,
    instr_fetch_stage_if.master    imem,
    output logic [INSTR_WIDTH-1:0] Instr_D,
    output logic [ADDR_WIDTH-1:0]  PC_D,
    output logic [ADDR_WIDTH-1:0]  PCPlus4_D,
    output logic                   InstrValid_D,
    output logic [6:0]             opcode_D,
    output logic [2:0]             funct3_D,
    output logic [6:0]             funct7_D
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            FetchCount,
    output logic [31:0]            BubbleCount
`endif
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    fetch_state_t           state_q;
    fetch_state_t           state_d;
    logic [ADDR_WIDTH-1:0]  pc_f;
    logic [ADDR_WIDTH-1:0]  pc_f_d;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic [INSTR_WIDTH-1:0] skid_dat;
    logic                   skid_load;
    logic                   deliver_vld;
    logic [INSTR_WIDTH-1:0] deliver_dat;
    logic                   ifid_load;
    logic                   ifid_bubble;

    assign pc_plus4    = pc_f + ADDR_WIDTH'(4);
    assign redirect_pc = {PCTarget_E[ADDR_WIDTH-1:2], 2'b00};

    // Gated by rst_n so no request escapes while reset is held (state already reads ISSUE).
    assign imem.imem_req  = rst_n && (state_q == ISSUE);
    assign imem.imem_addr = pc_f;

    always_comb begin
        state_d     = state_q;
        pc_f_d      = pc_f;
        skid_load   = 1'b0;
        deliver_vld = 1'b0;
        deliver_dat = imem.imem_rdata;
        case (state_q)
            ISSUE: begin
                state_d = PCSrc_E ? DROP : WAIT;
            end
            WAIT: begin
                if (PCSrc_E) begin
                    state_d = imem.imem_valid ? ISSUE : DROP;
                end else if (imem.imem_valid) begin
                    if (StallD) begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        deliver_vld = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end
            HOLD: begin
                if (PCSrc_E) begin
                    state_d = ISSUE;
                end else if (!StallD) begin
                    deliver_vld = 1'b1;
                    deliver_dat = skid_dat;
                    state_d     = ISSUE;
                end
            end
            DROP: begin
                // A redirect here keeps waiting for the stale response, unless that response
                // lands on the same edge -- then nothing is outstanding and we may reissue.
                if (imem.imem_valid) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase

        if (PCSrc_E) begin
            pc_f_d = redirect_pc;
        end else if (deliver_vld) begin
            pc_f_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ISSUE;
            pc_f     <= RESET_PC;
            skid_dat <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_f    <= pc_f_d;
            if (skid_load) begin
                skid_dat <= imem.imem_rdata;
            end
        end
    end

    // Flush beats stall beats a new instruction; anything else is a starvation bubble.
    assign ifid_load   = !FlushD && !StallD && deliver_vld;
    assign ifid_bubble = FlushD || (!StallD && !deliver_vld);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Instr_D      <= NOP_INSTR;
            PC_D         <= '0;
            PCPlus4_D    <= '0;
            InstrValid_D <= 1'b0;
        end else if (ifid_load) begin
            Instr_D      <= deliver_dat;
            PC_D         <= pc_f;
            PCPlus4_D    <= pc_plus4;
            InstrValid_D <= 1'b1;
        end else if (ifid_bubble) begin
            Instr_D      <= NOP_INSTR;
            InstrValid_D <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            FetchCount  <= '0;
            BubbleCount <= '0;
        end else begin
            if (ifid_load) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (ifid_bubble) begin
                BubbleCount <= BubbleCount + 32'd1;
            end
        end
    end
`endif

    assign opcode_D = Instr_D[6:0];
    assign funct3_D = Instr_D[14:12];
    assign funct7_D = Instr_D[31:25];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: memory responses are hand-driven per step,
// every expected value below is hand-computed from the fetch-stage behaviour.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallD;
    logic        FlushD;
    logic        PCSrc_E;
    logic [31:0] PCTarget_E;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PCPlus4_D;
    logic        InstrValid_D;
    logic [6:0]  opcode_D;
    logic [2:0]  funct3_D;
    logic [6:0]  funct7_D;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount;
    logic [31:0] BubbleCount;
`endif

    int vecs = 0;
    int errs = 0;

    instr_fetch_stage_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) imem_bus ();

    instr_fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .PCSrc_E      (PCSrc_E),
        .PCTarget_E   (PCTarget_E),
        .imem         (imem_bus),
        .Instr_D      (Instr_D),
        .PC_D         (PC_D),
        .PCPlus4_D    (PCPlus4_D),
        .InstrValid_D (InstrValid_D),
        .opcode_D     (opcode_D),
        .funct3_D     (funct3_D),
        .funct7_D     (funct7_D)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount   (FetchCount),
        .BubbleCount  (BubbleCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc, input logic [31:0] pc4, input logic vld);
        check({tag, ".Instr_D"}, Instr_D, instr);
        check({tag, ".PC_D"}, PC_D, pc);
        check({tag, ".PCPlus4_D"}, PCPlus4_D, pc4);
        check({tag, ".InstrValid_D"}, {31'd0, InstrValid_D}, {31'd0, vld});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, ".imem_req"}, {31'd0, imem_bus.imem_req}, {31'd0, req});
        check({tag, ".imem_addr"}, imem_bus.imem_addr, addr);
    endtask

    task automatic chk_bubble(input string tag);
        check({tag, ".Instr_D"}, Instr_D, 32'h0000_0013);
        check({tag, ".InstrValid_D"}, {31'd0, InstrValid_D}, 32'd0);
    endtask

    initial begin
        rst_n               = 1'b0;
        StallD              = 1'b0;
        FlushD              = 1'b0;
        PCSrc_E             = 1'b0;
        PCTarget_E          = 32'h0;
        imem_bus.imem_rdata = 32'h0;
        imem_bus.imem_valid = 1'b0;

        // Reset state
        step();
        step();
        chk_req("rst", 1'b0, 32'h0);
        chk_ifid("rst", 32'h0000_0013, 32'h0, 32'h0, 1'b0);

        // 1-cycle memory at 0x0
        rst_n = 1'b1;
        #1;
        chk_req("issue0", 1'b1, 32'h0);
        step();
        chk_req("wait0", 1'b0, 32'h0);
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 32'h0050_0093;
        step();
        chk_ifid("fetch0", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
        check("fetch0.opcode", {25'd0, opcode_D}, 32'h13);
        check("fetch0.funct3", {29'd0, funct3_D}, 32'h0);
        chk_req("issue4", 1'b1, 32'h4);
        imem_bus.imem_valid = 1'b0;

        // 3-cycle latency: single request pulse, bubbles while waiting
        step();
        chk_req("lat.w1", 1'b0, 32'h4);
        chk_bubble("lat.w1");
        step();
        chk_req("lat.w2", 1'b0, 32'h4);
        chk_bubble("lat.w2");
        step();
        chk_req("lat.w3", 1'b0, 32'h4);
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 32'h00a0_0113;
        step();
        chk_ifid("lat.fetch", 32'h00a0_0113, 32'h4, 32'h8, 1'b1);
        chk_req("issue8", 1'b1, 32'h8);
        imem_bus.imem_valid = 1'b0;

        // Stall for 4 cycles while the response arrives
        StallD = 1'b1;
        step();
        chk_ifid("stall.c1", 32'h00a0_0113, 32'h4, 32'h8, 1'b1);
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 32'h4020_81b3;
        step();
        chk_ifid("stall.c2", 32'h00a0_0113, 32'h4, 32'h8, 1'b1);
        chk_req("stall.c2", 1'b0, 32'h8);
        imem_bus.imem_valid = 1'b0;
        step();
        step();
        chk_ifid("stall.c4", 32'h00a0_0113, 32'h4, 32'h8, 1'b1);
        chk_req("stall.c4", 1'b0, 32'h8);
        StallD = 1'b0;
        step();
        chk_ifid("skid", 32'h4020_81b3, 32'h8, 32'hC, 1'b1);
        check("skid.opcode", {25'd0, opcode_D}, 32'h33);
        check("skid.funct7", {25'd0, funct7_D}, 32'h20);
        chk_req("issueC", 1'b1, 32'hC);
        step();
        chk_req("waitC", 1'b0, 32'hC);

        // Redirect while waiting: late response dropped, fetch resumes at 0x100
        PCSrc_E    = 1'b1;
        PCTarget_E = 32'h0000_0103;
        step();
        PCSrc_E    = 1'b0;
        chk_req("drop.c1", 1'b0, 32'h100);
        chk_bubble("drop.c1");
        step();
        chk_req("drop.c2", 1'b0, 32'h100);
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        chk_bubble("drop.late");
        chk_req("issue100", 1'b1, 32'h100);
        imem_bus.imem_valid = 1'b0;
        step();
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 32'h0010_0093;
        step();
        chk_ifid("redir.fetch", 32'h0010_0093, 32'h100, 32'h104, 1'b1);
        chk_req("issue104", 1'b1, 32'h104);
        imem_bus.imem_valid = 1'b0;

        // Flush and stall together: flush wins, PC fields kept
        FlushD = 1'b1;
        StallD = 1'b1;
        step();
        chk_ifid("flush+stall", 32'h0000_0013, 32'h100, 32'h104, 1'b0);
        FlushD = 1'b0;
        StallD = 1'b0;

        // Redirect with a response in the same cycle, then PC wrap at the top of memory
        PCSrc_E             = 1'b1;
        PCTarget_E          = 32'hFFFF_FFFC;
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 32'h1111_1111;
        step();
        PCSrc_E             = 1'b0;
        imem_bus.imem_valid = 1'b0;
        chk_bubble("redir.resp");
        chk_req("issueTop", 1'b1, 32'hFFFF_FFFC);
        step();
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 32'h0000_006F;
        step();
        chk_ifid("wrap", 32'h0000_006F, 32'hFFFF_FFFC, 32'h0, 1'b1);
        check("wrap.opcode", {25'd0, opcode_D}, 32'h6F);
        chk_req("wrap.next", 1'b1, 32'h0);
        imem_bus.imem_valid = 1'b0;

        // Reset in WAIT with a stray response around it
        step();
        rst_n               = 1'b0;
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 32'hBAD0_BAD3;
        #1;
        check("rstwait.req", {31'd0, imem_bus.imem_req}, 32'd0);
        step();
        chk_ifid("rstwait", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        chk_req("rstwait", 1'b0, 32'h0);
        rst_n = 1'b1;
        #1;
        chk_req("rst.issue", 1'b1, 32'h0);
        step();
        chk_bubble("stray");
        chk_req("stray", 1'b0, 32'h0);
        imem_bus.imem_rdata = 32'h0050_0093;
        step();
        chk_ifid("post.rst", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
        chk_req("post.rst", 1'b1, 32'h4);
        imem_bus.imem_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
